// File: rtl/line_key_scheduler_pkg.sv
// Shared constants, state encoding and LFSR/key helpers for the line key scheduler.
package scrambler_pkg;

  localparam logic [31:0] LFSR_TAPS       = 32'h80200003;
  localparam logic [31:0] LFSR_ZERO_SUB   = 32'h00000001;
  localparam int unsigned CUT_MAX_DEFAULT = 720;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2
  } sched_state_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h00000000);
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed is replaced.
  function automatic logic [31:0] seed_sanitize(input logic [31:0] s);
    seed_sanitize = (s == 32'h00000000) ? LFSR_ZERO_SUB : s;
  endfunction

  function automatic logic [9:0] key_reduce(input logic [9:0] r, input logic [9:0] cut_max);
    key_reduce = (r < cut_max) ? r : (r - cut_max);
  endfunction

endpackage

// File: rtl/line_key_scheduler_if.sv
// Seed/timing inputs and key outputs of the line key scheduler.
interface line_key_scheduler_if;

  logic [31:0] seed;
  logic        seed_ready;
  logic        line_start;
  logic        field_start;
  logic [9:0]  key;
  logic        key_valid;
  logic [9:0]  line_count;
  logic        locked;

  modport master (
    output seed, seed_ready, line_start, field_start,
    input  key, key_valid, line_count, locked
  );

  modport slave (
    input  seed, seed_ready, line_start, field_start,
    output key, key_valid, line_count, locked
  );

endinterface

// File: rtl/line_key_scheduler_key_lfsr32.sv
// 32-bit Galois LFSR with a load port; a load takes priority over a step.
module key_lfsr32
  import scrambler_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        step,
  output logic [31:0] state
);

  logic [31:0] state_r;

  // LFSR state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= 32'h00000000;
    end else if (load) begin
      state_r <= load_value;
    end else if (step) begin
      state_r <= lfsr_step(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/line_key_scheduler.sv
// Seeds an LFSR from the detected sequence and emits one cut-point key per video line.
// Build option: LINE_KEY_FIELD_RESEED_EN reloads the LFSR from the seed at every field start.
module line_key_scheduler
  import scrambler_pkg::*;
#(
  parameter int unsigned CUT_MAX = CUT_MAX_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  line_key_scheduler_if.slave  bus
);

`ifdef LINE_KEY_FIELD_RESEED_EN
  localparam logic FIELD_RESEED = 1'b1;
`else
  localparam logic FIELD_RESEED = 1'b0;
`endif

  localparam logic [9:0] CUT_MAX_W = 10'(CUT_MAX);

  sched_state_e state_r, state_next_s;
  logic        seed_ready_prev_r;
  logic [31:0] seed_q_r;
  logic [9:0]  key_r;
  logic        key_valid_r;
  logic [9:0]  line_count_r;
  logic        locked_r;

  logic        seed_rise_s;
  logic        field_load_s;
  logic        step_s;
  logic        count_clear_s;
  logic [31:0] lfsr_state_s;
  logic [31:0] base_s;
  logic [31:0] stepped_s;
  logic [9:0]  key_next_s;
  logic [9:0]  count_next_s;

  assign seed_rise_s = bus.seed_ready & ~seed_ready_prev_r;

  // Field action is applied before the line step, so a step starts from the reloaded seed.
  assign base_s     = field_load_s ? seed_q_r : lfsr_state_s;
  assign stepped_s  = lfsr_step(base_s);
  assign key_next_s = key_reduce(stepped_s[9:0], CUT_MAX_W);

  key_lfsr32 u_lfsr (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (field_load_s),
    .load_value (step_s ? stepped_s : seed_q_r),
    .step       (step_s & ~field_load_s),
    .state      (lfsr_state_s)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-cycle control decode; a seed edge overrides all timing pulses
  always_comb begin
    state_next_s  = state_r;
    field_load_s  = 1'b0;
    step_s        = 1'b0;
    count_clear_s = 1'b0;
    if (seed_rise_s) begin
      state_next_s = ARMED;
    end else begin
      case (state_r)
        IDLE: begin
          state_next_s = IDLE;
        end
        ARMED: begin
          if (bus.field_start) begin
            state_next_s  = RUNNING;
            field_load_s  = 1'b1;
            count_clear_s = 1'b1;
            step_s        = bus.line_start;
          end else begin
            state_next_s = ARMED;
          end
        end
        RUNNING: begin
          state_next_s  = RUNNING;
          field_load_s  = bus.field_start & FIELD_RESEED;
          count_clear_s = bus.field_start;
          step_s        = bus.line_start;
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // Line counter next value: clear on field, then saturating increment on a line step
  always_comb begin
    count_next_s = line_count_r;
    if (count_clear_s) begin
      count_next_s = step_s ? 10'd1 : 10'd0;
    end else if (step_s && (line_count_r != 10'd1023)) begin
      count_next_s = line_count_r + 10'd1;
    end else begin
      count_next_s = line_count_r;
    end
  end

  // Seed capture, edge register and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seed_ready_prev_r <= 1'b0;
      seed_q_r          <= 32'h00000000;
      key_r             <= 10'd0;
      key_valid_r       <= 1'b0;
      line_count_r      <= 10'd0;
      locked_r          <= 1'b0;
    end else begin
      seed_ready_prev_r <= bus.seed_ready;
      if (seed_rise_s) begin
        seed_q_r <= seed_sanitize(bus.seed);
      end else begin
        seed_q_r <= seed_q_r;
      end
      key_r        <= step_s ? key_next_s : key_r;
      key_valid_r  <= step_s;
      line_count_r <= count_next_s;
      locked_r     <= (state_next_s == RUNNING);
    end
  end

  assign bus.key        = key_r;
  assign bus.key_valid  = key_valid_r;
  assign bus.line_count = line_count_r;
  assign bus.locked     = locked_r;

endmodule
